// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared op/state encodings for the multiply/divide unit.
package mul_div_unit_pkg;
    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
    // Divide by zero leaves the remainder as the dividend and forces the quotient to all ones.
    localparam bit DIV0_LO_ONES = 1'b1;
endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// mul_div_unit_sign_fix: conditional two's-complement negate (abs on input, sign restore on output).
module mul_div_unit_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide with HI/LO registers.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e               state;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     md;
    logic                 is_div, neg_lo, neg_hi, div0;
    logic                 sgn;
    logic [WIDTH-1:0]     abs_a, abs_b, quo_y, rem_y;
    logic [2*WIDTH-1:0]   prod_y, next_acc;
    logic [WIDTH:0]       sum, rem_sh, diff;

    assign sgn = ~op[0];

    mul_div_unit_sign_fix #(.W(WIDTH)) u_abs_a (.x(a), .neg(sgn & a[WIDTH-1]), .y(abs_a));
    mul_div_unit_sign_fix #(.W(WIDTH)) u_abs_b (.x(b), .neg(sgn & b[WIDTH-1]), .y(abs_b));
    mul_div_unit_sign_fix #(.W(2*WIDTH)) u_prod (.x(acc), .neg(neg_lo), .y(prod_y));
    mul_div_unit_sign_fix #(.W(WIDTH)) u_quo (.x(acc[WIDTH-1:0]), .neg(neg_lo), .y(quo_y));
    mul_div_unit_sign_fix #(.W(WIDTH)) u_rem (.x(acc[2*WIDTH-1:WIDTH]), .neg(neg_hi), .y(rem_y));

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, md};
    assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
    assign diff   = rem_sh - {1'b0, md};
    assign next_acc = is_div
        ? (diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                       : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
        : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            md     <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        if (!op[2]) begin
                            acc    <= {{WIDTH{1'b0}}, abs_a};
                            md     <= abs_b;
                            is_div <= op[1];
                            neg_lo <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi <= sgn & a[WIDTH-1];
                            div0   <= (b == '0);
                            count  <= '0;
                            busy   <= 1'b1;
                            state  <= S_CALC;
                        end else if (op == MDU_MTHI) begin
                            hi <= a;
                        end else if (op == MDU_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc   <= next_acc;
                        count <= count + CNT_W'(1);
                        state <= (count == CNT_W'(WIDTH-1)) ? S_FIX : S_CALC;
                    end
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_y;
                            lo <= (div0 && DIV0_LO_ONES) ? '1 : quo_y;
                        end else begin
                            {hi, lo} <= prod_y;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
